// File: rtl/adc_offset_autocal.sv
// Offset auto-calibration sequencer: discards settling samples, averages 2^LOG2_AVG
// samples per channel, then writes the negated, saturated average per channel.
module adc_offset_autocal #(
  parameter int DATA_PATH_WIDTH = 16,
  parameter int N_CHANNELS      = 4,
  parameter int LOG2_AVG        = 8,
  parameter int SETTLE_SAMPLES  = 64,
  parameter int TIMEOUT_CYCLES  = 65536,
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              sample_valid,
  input  logic [CH_W-1:0]                   sample_channel,
  input  logic signed [DATA_PATH_WIDTH-1:0] sample_data,
  output logic                              offset_write,
  output logic [CH_W-1:0]                   offset_address,
  output logic signed [DATA_PATH_WIDTH-1:0] offset_data,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int W     = DATA_PATH_WIDTH;
  localparam int ACC_W = DATA_PATH_WIDTH + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam int ST_W  = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] COEF_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] COEF_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUMULATE,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state_q, state_d;
  logic [ST_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [CH_W-1:0] write_idx_q, write_idx_d;
  logic            offset_write_q, offset_write_d;
  logic [CH_W-1:0] offset_address_q, offset_address_d;
  logic [W-1:0]    offset_data_q, offset_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic                start_accept;
  logic                acc_en;
  logic [N_CHANNELS-1:0] full_d;
  logic signed [W-1:0] avg_all [N_CHANNELS];
  logic signed [W-1:0] avg_sel;
  logic signed [W:0]   neg_avg;
  logic [W-1:0]        coef;

  // The post-DONE cycle still reports busy, so start is refused there as well.
  assign start_accept = start && (state_q == S_IDLE) && !busy_q;
  assign acc_en       = (state_q == S_ACCUMULATE) && !abort && sample_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
      logic signed [ACC_W-1:0] acc_q, acc_d;
      logic [CNT_W-1:0]        cnt_q, cnt_d;

      always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start_accept) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (acc_en && (sample_channel == CH_W'(gi)) && !cnt_q[LOG2_AVG]) begin
          acc_d = acc_q + ACC_W'(sample_data);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end

      // Top bit of the count is set exactly when 2^LOG2_AVG samples are in.
      assign full_d[gi]  = cnt_d[LOG2_AVG];
      assign avg_all[gi] = acc_q[ACC_W-1:LOG2_AVG];
    end
  endgenerate

  // Dropping the low bits of the accumulator is the floor-average; only -MIN overflows.
  assign avg_sel = avg_all[write_idx_q];
  assign neg_avg = -{avg_sel[W-1], avg_sel};
  assign coef    = (neg_avg[W] != neg_avg[W-1]) ? (neg_avg[W] ? COEF_MIN : COEF_MAX)
                                                : neg_avg[W-1:0];

  always_comb begin
    state_d          = state_q;
    settle_cnt_d     = settle_cnt_q;
    timeout_cnt_d    = timeout_cnt_q;
    write_idx_d      = write_idx_q;
    offset_write_d   = 1'b0;
    offset_address_d = offset_address_q;
    offset_data_d    = offset_data_q;
    done_d           = 1'b0;
    error_d          = error_q;

    case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          state_d       = S_SETTLE;
          settle_cnt_d  = '0;
          timeout_cnt_d = '0;
          write_idx_d   = '0;
          error_d       = 1'b0;
        end
      end
      S_SETTLE: begin
        if (SETTLE_SAMPLES == 0) begin
          state_d = S_ACCUMULATE;
        end else if (sample_valid) begin
          settle_cnt_d = settle_cnt_q + ST_W'(1);
          if (settle_cnt_d == ST_W'(SETTLE_SAMPLES)) begin
            state_d = S_ACCUMULATE;
          end
        end
      end
      S_ACCUMULATE: begin
        timeout_cnt_d = timeout_cnt_q + TO_W'(1);
        if (&full_d) begin
          state_d = S_WRITE;
        end else if (timeout_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end
      end
      S_WRITE: begin
        offset_write_d   = 1'b1;
        offset_address_d = write_idx_q;
        offset_data_d    = coef;
        if (write_idx_q == CH_W'(N_CHANNELS - 1)) begin
          state_d = S_DONE;
        end else begin
          write_idx_d = write_idx_q + CH_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && abort) begin
      state_d          = S_IDLE;
      offset_write_d   = 1'b0;
      offset_address_d = offset_address_q;
      offset_data_d    = offset_data_q;
      done_d           = 1'b0;
      error_d          = error_q;
    end

    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      settle_cnt_q     <= '0;
      timeout_cnt_q    <= '0;
      write_idx_q      <= '0;
      offset_write_q   <= 1'b0;
      offset_address_q <= '0;
      offset_data_q    <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      timeout_cnt_q    <= timeout_cnt_d;
      write_idx_q      <= write_idx_d;
      offset_write_q   <= offset_write_d;
      offset_address_q <= offset_address_d;
      offset_data_q    <= offset_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

  assign offset_write   = offset_write_q;
  assign offset_address = offset_address_q;
  assign offset_data    = offset_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_adc_offset_autocal.sv
// Scoreboard bench for adc_offset_autocal: a sample-level model predicts each run's
// coefficient writes; a negedge monitor pops and compares them as they appear.
module tb_adc_offset_autocal;

  localparam int W       = 16;
  localparam int NCH     = 4;
  localparam int L2A     = 2;
  localparam int AVG_N   = 1 << L2A;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic               abort;
  logic               sample_valid;
  logic [1:0]         sample_channel;
  logic signed [W-1:0] sample_data;
  logic               offset_write;
  logic [1:0]         offset_address;
  logic signed [W-1:0] offset_data;
  logic               busy;
  logic               done;
  logic               error;

  adc_offset_autocal #(
    .DATA_PATH_WIDTH(W),
    .N_CHANNELS(NCH),
    .LOG2_AVG(L2A),
    .SETTLE_SAMPLES(SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .sample_valid(sample_valid),
    .sample_channel(sample_channel),
    .sample_data(sample_data),
    .offset_write(offset_write),
    .offset_address(offset_address),
    .offset_data(offset_data),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  done_cnt = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Negated floor-average, saturated to the signed coefficient range.
  function automatic int exp_coef(input int s);
    int avg;
    int neg;
    if (s >= 0) avg = s / AVG_N;
    else avg = -((-s + AVG_N - 1) / AVG_N);
    neg = -avg;
    if (neg > 32767) neg = 32767;
    if (neg < -32768) neg = -32768;
    return neg;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
      if (offset_write) begin
        check("write_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", int'(offset_address), mon_e.addr);
          check("wr_data", int'(offset_data), mon_e.data);
        end
      end
    end
  end

  // mode: 0 random, 1 const +100, 2 per-channel, 3 -32768, 4 +32767,
  //       5 ch3 starved (timeout), 6 abort in accumulate, 7 reset mid-write
  task automatic run_cal(input int mode);
    int sum[NCH];
    int cnt[NCH];
    int settle, acc_cyc, rr, d, ch, dc0;
    bit v, in_acc, finished, timed_out, aborted;
    logic signed [W-1:0] r16;
    wr_t e;
    settle = 0; acc_cyc = 0; rr = 0; in_acc = 0;
    finished = 0; timed_out = 0; aborted = 0;
    for (int i = 0; i < NCH; i++) begin
      sum[i] = 0;
      cnt[i] = 0;
    end
    dc0 = done_cnt;

    @(negedge clock);
    start = 1'b1;
    sample_valid = 1'b0;
    @(negedge clock);
    check("busy_rise", int'(busy), 1);
    check("error_clear", int'(error), 0);

    for (int cyc = 0; cyc < 400 && !finished && !timed_out && !aborted; cyc++) begin
      if (cyc > 0) @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      r16 = W'($urandom);
      v = 1'b1;
      ch = rr % NCH;
      d = int'(r16);
      case (mode)
        0, 6: begin
          v = ($urandom % 4) != 0;
          ch = int'($urandom % NCH);
        end
        1: d = 100;
        2: d = (ch == 0) ? -7 : (ch == 1) ? (((rr / NCH) % 2) ? -1 : 1) : (ch == 2) ? 1 : 3;
        3: d = -32768;
        4: d = 32767;
        5: ch = rr % 3;
        default: ;
      endcase
      if (mode == 0 && in_acc && ($urandom % 16) == 0) start = 1'b1;
      if (mode == 6 && in_acc && acc_cyc == 5) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      sample_valid   = v;
      sample_channel = 2'(ch);
      sample_data    = W'(d);
      if (v) rr++;

      if (!aborted) begin
        if (!in_acc) begin
          if (v) settle++;
          if (settle == SETTLE) in_acc = 1'b1;
        end else begin
          acc_cyc++;
          if (v && cnt[ch] < AVG_N) begin
            sum[ch] += d;
            cnt[ch]++;
          end
          if (cnt[0] == AVG_N && cnt[1] == AVG_N && cnt[2] == AVG_N && cnt[3] == AVG_N) begin
            finished = 1'b1;
            for (int i = 0; i < ((mode == 7) ? 2 : NCH); i++) begin
              e.addr = i;
              e.data = exp_coef(sum[i]);
              exp_q.push_back(e);
            end
          end else if (acc_cyc == TIMEOUT) begin
            timed_out = 1'b1;
          end
        end
      end
    end
    check("run_terminated", int'(finished || timed_out || aborted), 1);

    if (finished) begin
      for (int k = 0; k <= 6; k++) begin
        @(negedge clock);
        sample_valid   = 1'($urandom % 2);
        sample_channel = 2'($urandom % NCH);
        sample_data    = W'($urandom);
        if (mode == 7) begin
          if (k <= 2) check("wr_strobe", int'(offset_write), int'(k >= 1));
          if (k == 2) reset = 1'b0;
          if (k == 3) begin
            check("rst_write", int'(offset_write), 0);
            check("rst_addr", int'(offset_address), 0);
            check("rst_data", int'(offset_data), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_error", int'(error), 0);
            reset = 1'b1;
          end
        end else begin
          check("wr_strobe", int'(offset_write), int'(k >= 1 && k <= NCH));
          if (k == NCH + 1) begin
            check("done_pulse", int'(done), 1);
            check("busy_in_done", int'(busy), 1);
          end
          if (k == NCH + 2) begin
            check("done_clear", int'(done), 0);
            check("busy_fall", int'(busy), 0);
          end
        end
      end
      if (mode == 7) check("no_done_after_reset", done_cnt - dc0, 0);
    end

    if (timed_out) begin
      @(negedge clock);
      sample_valid = 1'b0;
      check("timeout_error", int'(error), 1);
      check("timeout_busy_hold", int'(busy), 1);
      @(negedge clock);
      check("timeout_busy_fall", int'(busy), 0);
      check("timeout_error_sticky", int'(error), 1);
      check("timeout_no_done", done_cnt - dc0, 0);
    end

    if (aborted) begin
      @(negedge clock);
      abort = 1'b0;
      check("abort_busy_fall", int'(busy), 0);
      for (int k = 0; k < 20; k++) begin
        sample_valid   = 1'b1;
        sample_channel = 2'(k % NCH);
        sample_data    = W'($urandom);
        @(negedge clock);
      end
      check("no_done_after_abort", done_cnt - dc0, 0);
    end

    sample_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    sample_valid = 1'b0;
    sample_channel = '0;
    sample_data = '0;
    repeat (3) @(negedge clock);
    check("reset_write", int'(offset_write), 0);
    check("reset_addr", int'(offset_address), 0);
    check("reset_data", int'(offset_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    reset = 1'b1;
    @(negedge clock);

    run_cal(1);
    run_cal(2);
    run_cal(3);
    run_cal(4);
    for (int i = 0; i < 6; i++) run_cal(0);
    run_cal(5);
    run_cal(0);
    run_cal(6);
    run_cal(7);
    run_cal(0);
    run_cal(2);

    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_offset_autocal.md
# adc_offset_autocal

Automatic offset-calibration sequencer for the ADC processing chain. During a calibration run the ADC inputs are held at a known zero. The block observes the raw sample stream upstream of the calibration stage and averages 2^LOG2_AVG samples per channel. It then writes the negated, saturated average into each channel's offset coefficient register. A small FSM sequences the run: settle, accumulate, compute/write, done, with timeout and abort handling.

## Interface
- DATA_PATH_WIDTH, 16, sample and coefficient width (signed).
- N_CHANNELS, 4, number of multiplexed ADC channels.
- LOG2_AVG, 8, log2 of samples averaged per channel.
- SETTLE_SAMPLES, 64, valid samples discarded after start, counted across all channels.
- TIMEOUT_CYCLES, 65536, maximum clock cycles allowed in ACCUMULATE.

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  single-cycle request to begin a run; ignored while busy.
- abort  in  1  ends the run immediately; no further coefficient writes.
- sample_valid  in  1  raw sample qualifier; always accepted, no backpressure.
- sample_channel  in  $clog2(N_CHANNELS)  channel index of the current sample.
- sample_data  in  DATA_PATH_WIDTH  signed raw sample.
- offset_write  out  1  one-cycle strobe; offset_address/offset_data are valid with it.
- offset_address  out  $clog2(N_CHANNELS)  channel being written.
- offset_data  out  DATA_PATH_WIDTH  signed offset coefficient.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag; cleared by the next accepted start.

## Operation
- States: IDLE, SETTLE, ACCUMULATE, WRITE, DONE, ERROR.
- IDLE:
  - start=1 clears all accumulators, per-channel counters, the settle counter, the timeout counter and error.
  - Transition to SETTLE.
- SETTLE:
  - Each sample_valid increments the settle counter; samples are discarded.
  - When the count reaches SETTLE_SAMPLES, transition to ACCUMULATE.
  - SETTLE_SAMPLES=0 goes directly to ACCUMULATE on the next cycle.
- ACCUMULATE:
  - Per channel: accumulator is signed, DATA_PATH_WIDTH+LOG2_AVG bits wide; sample counter is LOG2_AVG+1 bits.
  - On sample_valid, if that channel's count < 2^LOG2_AVG: acc += sample_data and count++.
  - Samples for an already-complete channel are ignored.
  - sample_channel >= N_CHANNELS is ignored.
  - When every channel reaches 2^LOG2_AVG, transition to WRITE. The sample that completes the last channel is included.
  - The timeout counter increments every cycle. On reaching TIMEOUT_CYCLES: go to ERROR, error=1, no writes.
- WRITE:
  - Processes one channel per cycle, index 0..N_CHANNELS-1.
  - avg = acc >>> LOG2_AVG (arithmetic shift, floor).
  - offset_data = -avg, saturated to [-2^(W-1), 2^(W-1)-1]; -(-32768) gives 32767 at W=16.
  - offset_write=1 with offset_address equal to the index.
  - After the last channel, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: go to IDLE the next cycle; error stays high.
- abort, from any non-IDLE state: IDLE next cycle, no further writes, error unchanged. Writes already issued in WRITE are not revoked.
- start while busy is ignored. Simultaneous start and abort in IDLE: start wins. In other states: abort wins.
- reset low mid-run: IDLE immediately; all counters and accumulators clear.

## Timing
- Reset values: offset_write=0, offset_address=0, offset_data=0, busy=0, done=0, error=0; state IDLE.
- busy rises the cycle after start is sampled.
- offset_write, offset_address and offset_data are registered.
  - First write appears 1 cycle after the ACCUMULATE→WRITE transition.
  - Writes are N_CHANNELS consecutive cycles, offset_write high each cycle.
- done is asserted the cycle after the last write; busy falls the cycle after done.
- offset_data holds its last written value between writes.
- Total latency, with no timeout:
  - up to the SETTLE_SAMPLES-th sample for SETTLE, then until all channels have 2^LOG2_AVG samples;
  - plus N_CHANNELS+2 cycles.

## Test plan
- Constant input, LOG2_AVG=2, N_CHANNELS=4, SETTLE_SAMPLES=4, round-robin channels, every channel = +100, start -> four writes (ch0..3, data -100, consecutive cycles), then done pulse, busy low.
- Per-channel values ch0=-7, ch1=0, ch2=1, ch3=3 (LOG2_AVG=2) with an alternating ±1 added to ch1 -> writes +7, 0, -1, -3; floor rounding checked on ch1 sum -1 → avg -1 → +1 where applicable.
- All channels input -32768 -> writes of 32767 (saturation); +32767 -> -32767.
- Only channels 0..2 receive samples, TIMEOUT_CYCLES=100 -> error=1, no offset_write, busy low; next start clears error.
- abort asserted during ACCUMULATE -> IDLE next cycle, zero writes, done never pulses; start during busy -> no effect on state or counters.
- reset low for 1 cycle during WRITE after 2 writes -> all outputs at reset values the following cycle, no further writes.
